// File: rtl/sseg_defs.sv
// Shared definitions for the seven-segment number writer.
// Holds FSM state encoding, BCD nibble width and decimal limit helper.
package sseg_defs;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_CONV,
        S_WRITE,
        S_DONE
    } state_e;

    localparam int NIB_W = 4;

    // Largest value that fits in n decimal digits: 10**n - 1.
    function automatic int max_val(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/sseg_num_writer_if.sv
// Request / display-array-write bundle of the seven-segment number writer.
// Requester side: start, value, dp_en, dp_pos, blink_in; writer side: status and write port.
interface sseg_num_writer_if #(
    parameter int VAL_BITS  = 10,
    parameter int SSEG_BITS = 2
);
    logic                 start;
    logic [VAL_BITS-1:0]  value;
    logic                 dp_en;
    logic [SSEG_BITS-1:0] dp_pos;
    logic                 blink_in;
    logic                 busy;
    logic                 done;
    logic                 wr;
    logic [SSEG_BITS-1:0] sel;
    logic [3:0]           val;
    logic                 sseg_en;
    logic                 sign;
    logic                 dp;
    logic                 blink;

    modport master (
        output start, value, dp_en, dp_pos, blink_in,
        input  busy, done, wr, sel, val, sseg_en, sign, dp, blink
    );

    modport slave (
        input  start, value, dp_en, dp_pos, blink_in,
        output busy, done, wr, sel, val, sseg_en, sign, dp, blink
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: load_i clears BCD and captures bin_i, each step_i does one add-3/shift.
// Ports: clk, reset (async, active-low), load_i, bin_i, step_i, bcd_o (look-ahead), ready_o.
module bin2bcd_seq
    import sseg_defs::*;
#(
    parameter int VAL_BITS = 10,
    parameter int DIGITS   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_i,
    input  logic [VAL_BITS-1:0]       bin_i,
    input  logic                      step_i,
    output logic [NIB_W*DIGITS-1:0]   bcd_o,
    output logic                      ready_o
);
    localparam int BW = NIB_W * DIGITS;
    localparam int CW = $clog2(VAL_BITS + 1);
    localparam logic [CW-1:0] FULL  = CW'(VAL_BITS);
    localparam logic [CW-1:0] LASTC = CW'(VAL_BITS - 1);

    logic [BW-1:0]       bcd_q, bcd_d, adj, sh;
    logic [VAL_BITS-1:0] bin_q, bin_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                adv;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[NIB_W*i +: NIB_W] >= 4'd5) begin
                adj[NIB_W*i +: NIB_W] = adj[NIB_W*i +: NIB_W] + 4'd3;
            end
        end
        sh    = {adj[BW-2:0], bin_q[VAL_BITS-1]};
        adv   = step_i && (cnt_q != FULL);
        bcd_d = bcd_q;
        bin_d = bin_q;
        cnt_d = cnt_q;
        if (load_i) begin
            bcd_d = '0;
            bin_d = bin_i;
            cnt_d = '0;
        end else if (adv) begin
            bcd_d = sh;
            bin_d = {bin_q[VAL_BITS-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
        end
    end

    // bcd_o shows the value after this cycle's step so the caller
    // can consume the final result on the same edge as the last shift.
    assign bcd_o   = adv ? sh : bcd_q;
    assign ready_o = (cnt_q == FULL) || (adv && cnt_q == LASTC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q <= '0;
            bin_q <= '0;
            cnt_q <= '0;
        end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sseg_num_writer.sv
// Signed binary to BCD converter that loads one digit per cycle into the display array.
// Ports: clk, reset (async, active-low), bus (slave); macro SSEG_NUM_WRITER_ZERO_BLANK_EN enables blanking.
module sseg_num_writer
    import sseg_defs::*;
#(
    parameter int VAL_BITS  = 10,
    parameter int SSEG_BITS = 2,
    parameter int SSEG_N    = 3
) (
    input  logic             clk,
    input  logic             reset,
    sseg_num_writer_if.slave bus
);
    localparam int BW = NIB_W * SSEG_N;
    localparam logic [SSEG_BITS-1:0] LAST = SSEG_BITS'(SSEG_N - 1);

    state_e               state_q, state_d;
    logic [SSEG_BITS-1:0] idx_q, idx_d;
    logic [VAL_BITS-1:0]  value_q, mag;
    logic                 dp_en_q, blink_req_q;
    logic [SSEG_BITS-1:0] dp_pos_q;
    logic                 neg_q, neg_d, ovf_q, ovf_d;
    logic                 load, step, ready;
    logic [BW-1:0]        bcd;

    logic                 busy_q, done_q, wr_q, en_q, sign_q, dp_q, blink_q;
    logic                 wr_d, en_d;
    logic [SSEG_BITS-1:0] sel_q;
    logic [3:0]           val_q, val_d, digit;
`ifdef SSEG_NUM_WRITER_ZERO_BLANK_EN
    logic                 hi_nz;
`endif

    bin2bcd_seq #(
        .VAL_BITS (VAL_BITS),
        .DIGITS   (SSEG_N)
    ) u_b2b (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .bin_i   (mag),
        .step_i  (step),
        .bcd_o   (bcd),
        .ready_o (ready)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        step    = 1'b0;
        mag     = value_q[VAL_BITS-1] ? (~value_q + 1'b1) : value_q;
        unique case (state_q)
            S_IDLE: if (bus.start) state_d = S_ABS;
            S_ABS: begin
                neg_d = value_q[VAL_BITS-1];
                ovf_d = 32'(mag) > 32'(max_val(SSEG_N));
                idx_d = '0;
                if (ovf_d) begin
                    state_d = S_WRITE;
                end else begin
                    load    = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                step = 1'b1;
                if (ready) begin
                    state_d = S_WRITE;
                    idx_d   = '0;
                end
            end
            S_WRITE: begin
                if (idx_q == LAST) state_d = S_DONE;
                else               idx_d   = idx_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output registers are driven from the next state, so the write port
    // lines up with the state that produces it.
    always_comb begin
        wr_d  = (state_d == S_WRITE);
        digit = '0;
        for (int j = 0; j < SSEG_N; j++) begin
            if (idx_d == SSEG_BITS'(j)) digit = bcd[NIB_W*j +: NIB_W];
        end
`ifdef SSEG_NUM_WRITER_ZERO_BLANK_EN
        hi_nz = 1'b0;
        for (int j = 0; j < SSEG_N; j++) begin
            if (SSEG_BITS'(j) >= idx_d && bcd[NIB_W*j +: NIB_W] != '0) hi_nz = 1'b1;
        end
        en_d = wr_d && (ovf_d || idx_d == '0 || hi_nz
             || (dp_en_q && dp_pos_q >= idx_d && dp_pos_q <= LAST)
             || (neg_d && idx_d == LAST));
`else
        en_d = wr_d;
`endif
        val_d = !wr_d ? 4'd0 : (ovf_d ? 4'd9 : digit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            value_q     <= '0;
            dp_en_q     <= 1'b0;
            dp_pos_q    <= '0;
            blink_req_q <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_q        <= 1'b0;
            sel_q       <= '0;
            val_q       <= '0;
            en_q        <= 1'b0;
            sign_q      <= 1'b0;
            dp_q        <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            if (state_q == S_IDLE && bus.start) begin
                value_q     <= bus.value;
                dp_en_q     <= bus.dp_en;
                dp_pos_q    <= bus.dp_pos;
                blink_req_q <= bus.blink_in;
            end
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            wr_q    <= wr_d;
            sel_q   <= wr_d ? idx_d : '0;
            val_q   <= val_d;
            en_q    <= en_d;
            sign_q  <= wr_d && neg_d && (idx_d == LAST);
            dp_q    <= wr_d && dp_en_q && (dp_pos_q == idx_d);
            blink_q <= wr_d && (blink_req_q || ovf_d);
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr      = wr_q;
    assign bus.sel     = sel_q;
    assign bus.val     = val_q;
    assign bus.sseg_en = en_q;
    assign bus.sign    = sign_q;
    assign bus.dp      = dp_q;
    assign bus.blink   = blink_q;
endmodule

// File: tb/tb_sseg_num_writer.sv
// Directed self-checking bench for sseg_num_writer (3-digit and 2-digit instances).
// Expectations follow SSEG_NUM_WRITER_ZERO_BLANK_EN to select blanked or shown leading zeros.
`timescale 1ns/1ps
module tb_sseg_num_writer;
    localparam int VB = 10;
    localparam int SB = 2;
`ifdef SSEG_NUM_WRITER_ZERO_BLANK_EN
    localparam bit NB = 1'b0;
`else
    localparam bit NB = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    sseg_num_writer_if #(.VAL_BITS(VB), .SSEG_BITS(SB)) bus ();
    sseg_num_writer_if #(.VAL_BITS(VB), .SSEG_BITS(SB)) bus2 ();

    sseg_num_writer #(.VAL_BITS(VB), .SSEG_BITS(SB), .SSEG_N(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sseg_num_writer #(.VAL_BITS(VB), .SSEG_BITS(SB), .SSEG_N(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] pk(input int s, input int v, input bit en,
                                      input bit sg, input bit dp, input bit bl);
        return {2'(s), 4'(v), en, sg, dp, bl};
    endfunction

    // {busy, done, wr, sel, val, sseg_en, sign, dp, blink}
    function automatic logic [12:0] obs(input bit which);
        if (which)
            return {bus2.busy, bus2.done, bus2.wr, bus2.sel, bus2.val,
                    bus2.sseg_en, bus2.sign, bus2.dp, bus2.blink};
        return {bus.busy, bus.done, bus.wr, bus.sel, bus.val,
                bus.sseg_en, bus.sign, bus.dp, bus.blink};
    endfunction

    task automatic run(input string nm, input bit which, input int v, input bit de,
                       input int dpp, input bit bl, input int poke, input int exp_done,
                       input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
        logic [9:0]  w [3];
        logic [12:0] o;
        int nw, nd, dat, nexp;
        nexp = which ? 2 : 3;
        for (int i = 0; i < 3; i++) w[i] = '1;
        nw = 0;
        nd = 0;
        dat = 0;
        @(negedge clk);
        bus.value  = 10'(v);  bus2.value  = 10'(v);
        bus.dp_en  = de;      bus2.dp_en  = de;
        bus.dp_pos = 2'(dpp); bus2.dp_pos = 2'(dpp);
        bus.blink_in = bl;    bus2.blink_in = bl;
        bus.start  = !which;
        bus2.start = which;
        @(negedge clk);
        o = obs(which);
        check({nm, ":busy_on"}, 32'(o[12]), 32'd1);
        for (int k = 1; k <= 30; k++) begin
            bus.start  = !which && (k == poke);
            bus2.start = which && (k == poke);
            o = obs(which);
            if (o[10]) begin
                if (nw < 3) w[nw] = o[9:0];
                nw++;
            end
            if (o[11]) begin
                nd++;
                if (dat == 0) dat = k;
            end
            @(negedge clk);
        end
        bus.start  = 1'b0;
        bus2.start = 1'b0;
        o = obs(which);
        check({nm, ":busy_off"}, 32'(o[12]), 32'd0);
        check({nm, ":n_wr"}, 32'(nw), 32'(nexp));
        check({nm, ":n_done"}, 32'(nd), 32'd1);
        check({nm, ":done_at"}, 32'(dat), 32'(exp_done));
        check({nm, ":w0"}, 32'(w[0]), 32'(e0));
        check({nm, ":w1"}, 32'(w[1]), 32'(e1));
        if (nexp == 3) check({nm, ":w2"}, 32'(w[2]), 32'(e2));
    endtask

    initial begin
        int nw, nd;
        bus.start = 1'b0;  bus.value = '0;  bus.dp_en = 1'b0;  bus.dp_pos = '0;  bus.blink_in = 1'b0;
        bus2.start = 1'b0; bus2.value = '0; bus2.dp_en = 1'b0; bus2.dp_pos = '0; bus2.blink_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'(obs(1'b0)), 32'd0);
        check("reset_outs2", 32'(obs(1'b1)), 32'd0);
        reset = 1'b1;

        run("v7", 0, 7, 0, 0, 0, 0, 15,
            pk(0, 7, 1, 0, 0, 0), pk(1, 0, NB, 0, 0, 0), pk(2, 0, NB, 0, 0, 0));
        run("m42", 0, -42, 0, 0, 0, 0, 15,
            pk(0, 2, 1, 0, 0, 0), pk(1, 4, 1, 0, 0, 0), pk(2, 0, 1, 1, 0, 0));
        run("m512", 0, -512, 0, 0, 0, 0, 15,
            pk(0, 2, 1, 0, 0, 0), pk(1, 1, 1, 0, 0, 0), pk(2, 5, 1, 1, 0, 0));
        run("p511", 0, 511, 0, 0, 0, 0, 15,
            pk(0, 1, 1, 0, 0, 0), pk(1, 1, 1, 0, 0, 0), pk(2, 5, 1, 0, 0, 0));
        run("z_dp1", 0, 0, 1, 1, 0, 0, 15,
            pk(0, 0, 1, 0, 0, 0), pk(1, 0, 1, 0, 1, 0), pk(2, 0, NB, 0, 0, 0));
        run("v50_dp0", 0, 50, 1, 0, 0, 0, 15,
            pk(0, 0, 1, 0, 1, 0), pk(1, 5, 1, 0, 0, 0), pk(2, 0, NB, 0, 0, 0));
        run("v123_poke", 0, 123, 0, 0, 0, 5, 15,
            pk(0, 3, 1, 0, 0, 0), pk(1, 2, 1, 0, 0, 0), pk(2, 1, 1, 0, 0, 0));
        run("v5_blink", 0, 5, 1, 3, 1, 0, 15,
            pk(0, 5, 1, 0, 0, 1), pk(1, 0, NB, 0, 0, 1), pk(2, 0, NB, 0, 0, 1));
        run("m7", 0, -7, 0, 0, 0, 0, 15,
            pk(0, 7, 1, 0, 0, 0), pk(1, 0, NB, 0, 0, 0), pk(2, 0, 1, 1, 0, 0));

        run("n2_100", 1, 100, 0, 0, 0, 0, 4,
            pk(0, 9, 1, 0, 0, 1), pk(1, 9, 1, 0, 0, 1), '0);
        run("n2_m100", 1, -100, 0, 0, 0, 0, 4,
            pk(0, 9, 1, 0, 0, 1), pk(1, 9, 1, 1, 0, 1), '0);
        run("n2_99", 1, 99, 0, 0, 0, 0, 14,
            pk(0, 9, 1, 0, 0, 0), pk(1, 9, 1, 0, 0, 0), '0);
        run("n2_m5", 1, -5, 0, 0, 0, 0, 14,
            pk(0, 5, 1, 0, 0, 0), pk(1, 0, 1, 1, 0, 0), '0);

        @(negedge clk);
        bus.value = 10'd123;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_conv_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_async_outs", 32'(obs(1'b0)), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        nw = 0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.wr) nw++;
            if (bus.done) nd++;
            @(negedge clk);
        end
        check("rst_no_wr", 32'(nw), 32'd0);
        check("rst_no_done", 32'(nd), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
